// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard controller.
//   fwd_sel_t  - E-stage operand forwarding select (00 RF, 01 ResultW, 10 ALUResultM)
//   md_state_t - multiply/divide sequencer state
//   fwdSel()   - forwarding priority decode for one E-stage source register
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // M is younger than W, so it wins; x0 is hard-wired zero and never forwarded.
    function automatic fwd_sel_t fwdSel(
        input logic [4:0] rsE,
        input logic [4:0] rdM,
        input logic [4:0] rdW,
        input logic       regWriteM,
        input logic       regWriteW
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (regWriteM && (rdM != 5'd0) && (rdM == rsE)) begin
            sel = FWD_M;
        end else if (regWriteW && (rdW != 5'd0) && (rdW == rsE)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// hazard_if: bundle between the pipeline datapath and the hazard controller.
//   master modport - datapath side: drives register ids / control levels,
//                    receives stall, flush, forwarding and counter outputs.
//   slave modport  - hazard_ctrl side (the reverse directions).
// Handshake: MdE is a request level held by the datapath while a mul/div op
// sits in E; the op is complete when MdDoneE is high at a rising clk edge,
// and E advances at that same edge. No other signal in this bundle
// handshakes; all are plain per-cycle levels.
// mdState is a debug view of the mul/div sequencer state.
interface hazard_if #(
    parameter int CNT_W = 32
);
    import hazard_pkg::*;

    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             LoadE;
    logic             PCSrcE;
    logic             MdE;

    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    fwd_sel_t         ForwardAE;
    fwd_sel_t         ForwardBE;
    logic             MdDoneE;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;
    logic [CNT_W-1:0] RedirCnt;
    md_state_t        mdState;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, LoadE, PCSrcE, MdE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
        input  ForwardAE, ForwardBE, MdDoneE,
        input  StallCnt, FlushCnt, RedirCnt, mdState
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, LoadE, PCSrcE, MdE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
        output ForwardAE, ForwardBE, MdDoneE,
        output StallCnt, FlushCnt, RedirCnt, mdState
    );

endinterface

// File: rtl/hazard_ctrl_md_sequencer.sv
// md_sequencer: holds a multiply/divide op in the E stage for MD_LATENCY cycles.
//   clk, reset - core clock, asynchronous active-high reset
//   MdE        - E holds a mul/div op (level); ignored while BUSY
//   stall      - hold F/D/E and bubble M this cycle
//   done       - last cycle of the op; E advances at the next edge
//   state      - debug view of the FSM state
// The stall window starts combinationally in the cycle MdE is seen in IDLE,
// then continues from registered state for MD_LATENCY-1 more cycles.
module md_sequencer
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      MdE,
    output logic      stall,
    output logic      done,
    output md_state_t state
);

    localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt;
    logic          busyStall;   // registered: BUSY with cnt != 0

    // With MD_LATENCY==1 the load value is 0, so the op goes straight from
    // the IDLE stall cycle to the done cycle without any BUSY stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            busyStall <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (MdE) begin
                        state     <= BUSY;
                        cnt       <= CNT_LOAD;
                        busyStall <= (CNT_LOAD != '0);
                        done      <= (CNT_LOAD == '0);
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt       <= cnt - CNT_ONE;
                        busyStall <= (cnt != CNT_ONE);
                        done      <= (cnt == CNT_ONE);
                    end else begin
                        state     <= IDLE;
                        busyStall <= 1'b0;
                        done      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    busyStall <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    assign stall = ((state == IDLE) && MdE) || busyStall;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central hazard/stall controller for the 5-stage RV32 pipeline.
//   clk, reset - core clock, asynchronous active-high reset
//   hz (slave) - register ids and control levels in; StallF/D/E, FlushD/E/M,
//                ForwardAE/BE, MdDoneE and performance counters out
// Optional feature macro: HAZARD_PERF_EN builds the StallCnt/FlushCnt/RedirCnt
// counters; when undefined the counter outputs are tied to zero.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 32
) (
    input  logic clk,
    input  logic reset,
    hazard_if.slave hz
);

    logic loadUse;
    logic redirect;
    logic mdStall;
    logic mdDone;

    md_sequencer #(
        .MD_LATENCY(MD_LATENCY)
    ) uMdSeq (
        .clk   (clk),
        .reset (reset),
        .MdE   (hz.MdE),
        .stall (mdStall),
        .done  (mdDone),
        .state (hz.mdState)
    );

    assign hz.ForwardAE = fwdSel(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
    assign hz.ForwardBE = fwdSel(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);

    assign loadUse  = hz.LoadE && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    assign redirect = hz.PCSrcE;

    // A redirect makes the D instruction wrong-path, so it cancels the
    // load-use stall. While the mul/div op holds E, LoadE/PCSrcE describe
    // nothing real and the flushes are suppressed so the op is never killed.
    assign hz.StallF  = (loadUse && !redirect) || mdStall;
    assign hz.StallD  = (loadUse && !redirect) || mdStall;
    assign hz.StallE  = mdStall;
    assign hz.FlushD  = redirect && !mdStall;
    assign hz.FlushE  = (loadUse || redirect) && !mdStall;
    assign hz.FlushM  = mdStall;
    assign hz.MdDoneE = mdDone;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;
    logic [CNT_W-1:0] redirCnt;

    // Free-running counters; wrap naturally modulo 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
            redirCnt <= '0;
        end else begin
            if (hz.StallF) stallCnt <= stallCnt + CNT_W'(1);
            if (hz.FlushE) flushCnt <= flushCnt + CNT_W'(1);
            if (hz.PCSrcE) redirCnt <= redirCnt + CNT_W'(1);
        end
    end

    assign hz.StallCnt = stallCnt;
    assign hz.FlushCnt = flushCnt;
    assign hz.RedirCnt = redirCnt;
`else
    assign hz.StallCnt = '0;
    assign hz.FlushCnt = '0;
    assign hz.RedirCnt = '0;
`endif

endmodule
